// File: rtl/lcd_pkg.sv
`default_nettype none
//============================================================================
// Package : lcd_pkg
// Brief   : Shared state encoding and PCD8544 command bytes for the LCD
//           frame sequencer.
// Rev     : 1.0
//============================================================================
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_LCD_RST   = 4'd0,
        ST_INIT_SEND = 4'd1,
        ST_INIT_WAIT = 4'd2,
        ST_IDLE      = 4'd3,
        ST_CMD_SEND  = 4'd4,
        ST_CMD_WAIT  = 4'd5,
        ST_FB_READ   = 4'd6,
        ST_FB_SEND   = 4'd7,
        ST_FB_WAIT   = 4'd8
    } state_t;

    localparam int INIT_LEN   = 6;
    localparam int INIT_IDX_W = 3;

    localparam logic [7:0] CMD_FUNC_EXT    = 8'h21;
    localparam logic [7:0] CMD_SET_VOP     = 8'hB1;
    localparam logic [7:0] CMD_TEMP_COEF   = 8'h04;
    localparam logic [7:0] CMD_BIAS        = 8'h14;
    localparam logic [7:0] CMD_FUNC_BASIC  = 8'h20;
    localparam logic [7:0] CMD_DISP_NORMAL = 8'h0C;
    localparam logic [7:0] CMD_SET_Y       = 8'h40;
    localparam logic [7:0] CMD_SET_X       = 8'h80;

endpackage
`default_nettype wire

// File: rtl/lcd_frame_sequencer_if.sv
`default_nettype none
//============================================================================
// Interface : lcd_frame_sequencer_if
// Brief     : Refresh request, frame-buffer read port, SPI master handshake
//             and LCD status signals of the frame sequencer.
// Rev       : 1.0
//============================================================================
interface lcd_frame_sequencer_if;

    logic       refresh;
    logic       fb_rd;
    logic [8:0] fb_addr;
    logic [7:0] fb_data;
    logic [7:0] spi_data;
    logic       spi_start;
    logic       spi_dc;
    logic       spi_busy;
    logic       spi_avail;
    logic       lcd_rst;
    logic       ready;
    logic       frame_done;

    modport master (
        input  refresh, fb_data, spi_busy, spi_avail,
        output fb_rd, fb_addr, spi_data, spi_start, spi_dc, lcd_rst, ready, frame_done
    );

    modport slave (
        output refresh, fb_data, spi_busy, spi_avail,
        input  fb_rd, fb_addr, spi_data, spi_start, spi_dc, lcd_rst, ready, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/lcd_init_rom.sv
`default_nettype none
//============================================================================
// Module : lcd_init_rom
// Brief  : Combinational map from init-sequence index to command byte.
// Rev    : 1.0
//============================================================================
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [INIT_IDX_W-1:0] i_idx,
    output logic [7:0]            o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_idx)
            3'd0:    o_byte = CMD_FUNC_EXT;
            3'd1:    o_byte = CMD_SET_VOP;
            3'd2:    o_byte = CMD_TEMP_COEF;
            3'd3:    o_byte = CMD_BIAS;
            3'd4:    o_byte = CMD_FUNC_BASIC;
            3'd5:    o_byte = CMD_DISP_NORMAL;
            default: o_byte = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lcd_frame_sequencer.sv
`default_nettype none
//============================================================================
// Module : lcd_frame_sequencer
// Brief  : Resets and initialises an 84x48 LCD, then streams a full frame
//          buffer to an SPI master on each refresh request.
// Rev    : 1.0
//============================================================================
module lcd_frame_sequencer
    import lcd_pkg::*;
#(
    parameter int RST_CYCLES = 100,
    parameter int FB_BYTES   = 504
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_frame_sequencer_if.master bus
);

    localparam int                    CNT_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0]      RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [8:0]            FB_LAST   = 9'(FB_BYTES - 1);
    localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(INIT_LEN - 1);

    state_t                r_state,      w_state_nxt;
    logic [CNT_W-1:0]      r_rst_cnt,    w_rst_cnt_nxt;
    logic [INIT_IDX_W-1:0] r_init_idx,   w_init_idx_nxt;
    logic                  r_cmd_sel,    w_cmd_sel_nxt;
    logic [8:0]            r_fb_addr,    w_fb_addr_nxt;
    logic                  r_fb_first,   w_fb_first_nxt;
    logic                  r_pending,    w_pending_nxt;
    logic [7:0]            r_spi_data,   w_spi_data_nxt;
    logic                  r_spi_dc,     w_spi_dc_nxt;
    logic                  r_spi_start,  w_spi_start_nxt;
    logic                  r_frame_done, w_frame_done_nxt;
    logic [7:0]            w_rom_byte;

    lcd_init_rom u_init_rom (
        .i_idx  (r_init_idx),
        .o_byte (w_rom_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_LCD_RST;
            r_rst_cnt    <= '0;
            r_init_idx   <= '0;
            r_cmd_sel    <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_first   <= 1'b0;
            r_pending    <= 1'b0;
            r_spi_data   <= 8'h00;
            r_spi_dc     <= 1'b0;
            r_spi_start  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_init_idx   <= w_init_idx_nxt;
            r_cmd_sel    <= w_cmd_sel_nxt;
            r_fb_addr    <= w_fb_addr_nxt;
            r_fb_first   <= w_fb_first_nxt;
            r_pending    <= w_pending_nxt;
            r_spi_data   <= w_spi_data_nxt;
            r_spi_dc     <= w_spi_dc_nxt;
            r_spi_start  <= w_spi_start_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // spi_start/data/dc are registered together so the byte and its type are
    // already valid in the launch cycle and hold until the next launch.
    always_comb begin
        w_state_nxt      = r_state;
        w_rst_cnt_nxt    = r_rst_cnt;
        w_init_idx_nxt   = r_init_idx;
        w_cmd_sel_nxt    = r_cmd_sel;
        w_fb_addr_nxt    = r_fb_addr;
        w_fb_first_nxt   = r_fb_first;
        w_pending_nxt    = r_pending | (bus.refresh & (r_state != ST_IDLE));
        w_spi_data_nxt   = r_spi_data;
        w_spi_dc_nxt     = r_spi_dc;
        w_spi_start_nxt  = 1'b0;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            ST_LCD_RST: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_rst_cnt_nxt = '0;
                    w_state_nxt   = ST_INIT_SEND;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                end
            end
            ST_INIT_SEND: begin
                if (!bus.spi_busy) begin
                    w_spi_start_nxt = 1'b1;
                    w_spi_data_nxt  = w_rom_byte;
                    w_spi_dc_nxt    = 1'b0;
                    w_state_nxt     = ST_INIT_WAIT;
                end
            end
            ST_INIT_WAIT: begin
                if (bus.spi_avail) begin
                    if (r_init_idx == INIT_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_init_idx_nxt = r_init_idx + 1'b1;
                        w_state_nxt    = ST_INIT_SEND;
                    end
                end
            end
            ST_IDLE: begin
                if (bus.refresh || r_pending) begin
                    w_pending_nxt = 1'b0;
                    w_fb_addr_nxt = '0;
                    w_cmd_sel_nxt = 1'b0;
                    w_state_nxt   = ST_CMD_SEND;
                end
            end
            ST_CMD_SEND: begin
                if (!bus.spi_busy) begin
                    w_spi_start_nxt = 1'b1;
                    w_spi_data_nxt  = r_cmd_sel ? CMD_SET_X : CMD_SET_Y;
                    w_spi_dc_nxt    = 1'b0;
                    w_state_nxt     = ST_CMD_WAIT;
                end
            end
            ST_CMD_WAIT: begin
                if (bus.spi_avail) begin
                    if (r_cmd_sel) begin
                        w_state_nxt = ST_FB_READ;
                    end else begin
                        w_cmd_sel_nxt = 1'b1;
                        w_state_nxt   = ST_CMD_SEND;
                    end
                end
            end
            ST_FB_READ: begin
                w_fb_first_nxt = 1'b1;
                w_state_nxt    = ST_FB_SEND;
            end
            ST_FB_SEND: begin
                // fb_data is only valid in the first FB_SEND cycle; keep it
                // in spi_data in case the SPI master stalls us.
                if (r_fb_first) begin
                    w_spi_data_nxt = bus.fb_data;
                    w_fb_first_nxt = 1'b0;
                end
                if (!bus.spi_busy) begin
                    w_spi_start_nxt = 1'b1;
                    w_spi_dc_nxt    = 1'b1;
                    w_state_nxt     = ST_FB_WAIT;
                end
            end
            ST_FB_WAIT: begin
                if (bus.spi_avail) begin
                    if (r_fb_addr == FB_LAST) begin
                        w_frame_done_nxt = 1'b1;
                        w_state_nxt      = ST_IDLE;
                    end else begin
                        w_fb_addr_nxt = r_fb_addr + 9'd1;
                        w_state_nxt   = ST_FB_READ;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_LCD_RST;
            end
        endcase
    end

    assign bus.fb_rd      = (r_state == ST_FB_READ);
    assign bus.fb_addr    = r_fb_addr;
    assign bus.spi_data   = r_spi_data;
    assign bus.spi_start  = r_spi_start;
    assign bus.spi_dc     = r_spi_dc;
    assign bus.lcd_rst    = (r_state != ST_LCD_RST);
    assign bus.ready      = (r_state == ST_IDLE);
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_sequencer.sv
`default_nettype none
//============================================================================
// Module : tb_lcd_frame_sequencer
// Brief  : Directed self-checking bench with an SPI master and frame-buffer
//          model; bytes launched by the DUT are logged as {dc, data}.
// Rev    : 1.0
//============================================================================
module tb_lcd_frame_sequencer;

    localparam int RST_CYC = 10;
    localparam int FB_N    = 504;
    localparam int SPI_LAT = 20;

    logic clk;
    logic reset;
    lcd_frame_sequencer_if bus();

    lcd_frame_sequencer #(
        .RST_CYCLES (RST_CYC),
        .FB_BYTES   (FB_N)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         cyc       = 0;
    int         avail_cyc = 0;
    int         start_cnt = 0;
    int         fd_cnt    = 0;
    int         stab_err  = 0;
    int         spi_cnt   = 0;
    bit         stab_en   = 1'b0;
    bit         hold_busy = 1'b0;
    logic       start_seen;
    logic [8:0] last_sent;
    logic [8:0] sent [$];
    logic [7:0] init_exp [6] = '{8'h21, 8'hB1, 8'h04, 8'h14, 8'h20, 8'h0C};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SPI master: busy from the cycle after a launch, avail 20 cycles after it
    initial begin
        bus.spi_busy  = 1'b0;
        bus.spi_avail = 1'b0;
        forever begin
            @(negedge clk);
            start_seen = bus.spi_start;
            if (bus.frame_done === 1'b1) fd_cnt++;
            if (start_seen === 1'b1) begin
                last_sent = {bus.spi_dc, bus.spi_data};
                sent.push_back(last_sent);
                start_cnt++;
            end else if (stab_en && spi_cnt != 0 && {bus.spi_dc, bus.spi_data} !== last_sent) begin
                stab_err++;
            end
            @(posedge clk); #1;
            bus.spi_avail = 1'b0;
            if (start_seen === 1'b1) begin
                spi_cnt = 1;
            end else if (spi_cnt != 0) begin
                spi_cnt++;
                if (spi_cnt == SPI_LAT) begin
                    bus.spi_avail = 1'b1;
                    avail_cyc     = cyc;
                    spi_cnt       = 0;
                end
            end
            bus.spi_busy = (spi_cnt != 0) || hold_busy;
        end
    end

    // Frame buffer: returns addr[7:0] exactly one cycle after fb_rd
    initial begin
        logic       rd_seen;
        logic [8:0] rd_addr;
        bus.fb_data = 8'hEE;
        forever begin
            @(negedge clk);
            rd_seen = bus.fb_rd;
            rd_addr = bus.fb_addr;
            @(posedge clk); #1;
            bus.fb_data = (rd_seen === 1'b1) ? rd_addr[7:0] : 8'hEE;
        end
    end

    task automatic tick();
        @(posedge clk); #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_lcd_rst"},    32'(bus.lcd_rst),    32'd0);
        chk({pfx, "_spi_start"},  32'(bus.spi_start),  32'd0);
        chk({pfx, "_spi_data"},   32'(bus.spi_data),   32'd0);
        chk({pfx, "_spi_dc"},     32'(bus.spi_dc),     32'd0);
        chk({pfx, "_fb_rd"},      32'(bus.fb_rd),      32'd0);
        chk({pfx, "_fb_addr"},    32'(bus.fb_addr),    32'd0);
        chk({pfx, "_ready"},      32'(bus.ready),      32'd0);
        chk({pfx, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    endtask

    task automatic chk_init_log(input string pfx);
        chk({pfx, "_count"}, 32'(sent.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_byte%0d", pfx, i), 32'(sent[i]), 32'({1'b0, init_exp[i]}));
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (bus.ready !== 1'b1 && n < limit) begin n++; tick(); end
    endtask

    task automatic wait_frame_done(input int limit);
        int n = 0;
        while (bus.frame_done !== 1'b1 && n < limit) begin n++; tick(); end
    endtask

    initial begin
        int         n;
        int         fd0;
        int         s0;
        logic [7:0] b;

        reset       = 1'b1;
        bus.refresh = 1'b0;

        // Scenario 1: reset values and LCD reset pulse length
        repeat (3) tick();
        chk_reset_outputs("rst");
        reset   = 1'b0;
        stab_en = 1'b1;
        sent.delete();
        n = 0;
        while (bus.lcd_rst === 1'b0 && n < 1000) begin n++; tick(); end
        chk("lcd_rst_low_cycles", 32'(n), 32'(RST_CYC));

        // Scenario 2: init sequence then ready
        wait_ready(2000);
        chk("init_ready", 32'(bus.ready), 32'd1);
        chk_init_log("init");

        // Scenario 3: one full frame
        sent.delete();
        fd0 = fd_cnt;
        bus.refresh = 1'b1; tick(); bus.refresh = 1'b0;
        chk("frame_busy_ready", 32'(bus.ready), 32'd0);
        wait_frame_done(20000);
        chk("fd_seen", 32'(bus.frame_done), 32'd1);
        chk("fd_ready_same_cycle", 32'(bus.ready), 32'd1);
        chk("fd_after_last_avail", 32'(cyc), 32'(avail_cyc + 1));
        repeat (5) tick();
        chk("fd_single_pulse", 32'(fd_cnt - fd0), 32'd1);
        chk("frame_len", 32'(sent.size()), 32'(FB_N + 2));
        chk("frame_cmd_y", 32'(sent[0]), 32'h040);
        chk("frame_cmd_x", 32'(sent[1]), 32'h080);
        for (int i = 0; i < FB_N; i++) begin
            b = 8'(i);
            chk($sformatf("frame_data%0d", i), 32'(sent[i + 2]), 32'({1'b1, b}));
        end

        // Scenario 4: three refreshes mid-frame plus one in the frame_done cycle
        sent.delete();
        fd0 = fd_cnt;
        bus.refresh = 1'b1; tick(); bus.refresh = 1'b0;
        repeat (3) begin
            repeat (300) tick();
            bus.refresh = 1'b1; tick(); bus.refresh = 1'b0;
        end
        wait_frame_done(20000);
        bus.refresh = 1'b1; tick(); bus.refresh = 1'b0;
        chk("pend_restart", 32'(bus.ready), 32'd0);
        wait_frame_done(20000);
        repeat (100) tick();
        chk("pend_frames", 32'(fd_cnt - fd0), 32'd2);
        chk("pend_idle", 32'(bus.ready), 32'd1);
        chk("pend_len", 32'(sent.size()), 32'(2 * (FB_N + 2)));
        chk("pend_f2_cmd_y", 32'(sent[FB_N + 2]), 32'h040);
        chk("pend_f2_cmd_x", 32'(sent[FB_N + 3]), 32'h080);
        chk("pend_f2_addr0", 32'(sent[FB_N + 4]), 32'h100);
        chk("pend_f2_last", 32'(sent[2 * FB_N + 3]), 32'h1F7);

        // Scenario 5: reset mid-frame at data byte 100 with a request pending
        sent.delete();
        bus.refresh = 1'b1; tick(); bus.refresh = 1'b0;
        n = 0;
        while (bus.fb_addr !== 9'd90 && n < 5000) begin n++; tick(); end
        bus.refresh = 1'b1; tick(); bus.refresh = 1'b0;
        n = 0;
        while (!(bus.fb_addr === 9'd100 && bus.spi_busy === 1'b1) && n < 5000) begin n++; tick(); end
        chk("mid_addr_reached", 32'(bus.fb_addr), 32'd100);
        reset   = 1'b1;
        stab_en = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        reset = 1'b0;
        sent.delete();
        repeat (25) tick();
        stab_en = 1'b1;
        wait_ready(2000);
        chk("reinit_ready", 32'(bus.ready), 32'd1);
        chk_init_log("reinit");
        repeat (60) tick();
        chk("pend_cleared_idle", 32'(bus.ready), 32'd1);
        chk("pend_cleared_len", 32'(sent.size()), 32'd6);

        // Scenario 6: spi_busy held through CMD_SEND
        sent.delete();
        s0 = start_cnt;
        hold_busy = 1'b1; tick();
        bus.refresh = 1'b1; tick(); bus.refresh = 1'b0;
        repeat (50) tick();
        chk("stall_no_start", 32'(start_cnt - s0), 32'd0);
        chk("stall_not_idle", 32'(bus.ready), 32'd0);
        hold_busy = 1'b0;
        repeat (5) tick();
        chk("stall_one_start", 32'(start_cnt - s0), 32'd1);
        chk("stall_cmd_y", 32'(sent[0]), 32'h040);

        chk("byte_stability", 32'(stab_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_frame_sequencer.md
LCD_FRAME_SEQUENCER -- requirements
Module: lcd_frame_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 100: clk cycles the LCD hardware reset is held low.
REQ-002 Parameter FB_BYTES, default 504: frame size in bytes (84x48 / 8).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 refresh  input  1  request to transfer one full frame; a single-cycle pulse is sufficient.
REQ-006 fb_rd  output  1  frame-buffer read strobe.
REQ-007 fb_addr  output  9  frame-buffer byte address, 0..FB_BYTES-1.
REQ-008 fb_data  input  8  frame-buffer byte, valid exactly 1 cycle after fb_rd.
REQ-009 spi_data  output  8  byte to the downstream SPI master (its data_in).
REQ-010 spi_start  output  1  one-cycle launch pulse to the SPI master.
REQ-011 spi_dc  output  1  0 = command byte, 1 = display data byte; stable from spi_start until the matching spi_avail.
REQ-012 spi_busy  input  1  SPI master transfer in progress.
REQ-013 spi_avail  input  1  one-cycle pulse from the SPI master: byte transfer complete.
REQ-014 lcd_rst  output  1  active-low LCD hardware reset pin.
REQ-015 ready  output  1  high only in IDLE.
REQ-016 frame_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-017 FSM states: LCD_RST, INIT_SEND, INIT_WAIT, IDLE, CMD_SEND, CMD_WAIT, FB_READ, FB_SEND, FB_WAIT.
REQ-018 LCD_RST: lcd_rst=0 for exactly RST_CYCLES cycles, then lcd_rst=1 and go to INIT_SEND.
REQ-019 Init sequence, all with spi_dc=0, in this order: 0x21, 0xB1, 0x04, 0x14, 0x20, 0x0C.
REQ-020 Byte handshake: spi_start asserts for one cycle only when spi_busy=0; the FSM then waits in *_WAIT for spi_avail; no new spi_start until spi_avail is seen.
REQ-021 spi_data holds its value from the spi_start cycle until spi_avail.
REQ-022 After the 6th init byte completes, go to IDLE; ready=1.
REQ-023 In IDLE, a refresh or pending request starts a frame: commands 0x40 then 0x80 (spi_dc=0), then FB_BYTES data bytes (spi_dc=1).
REQ-024 Per data byte: FB_READ asserts fb_rd for one cycle with fb_addr=n. FB_SEND captures fb_data on the next cycle and issues spi_start. FB_WAIT waits for spi_avail.
REQ-025 fb_addr runs from 0 to FB_BYTES-1 with no wrap within a frame and resets to 0 at frame start.
REQ-026 frame_done pulses in the cycle after the spi_avail of byte FB_BYTES-1; the FSM returns to IDLE in that same cycle.
REQ-027 A refresh arriving outside IDLE sets a single pending flag, which is not counted; the flag is cleared when the next frame starts.
REQ-028 A refresh in IDLE and the frame_done cycle together start exactly one new frame.
REQ-029 spi_avail outside a *_WAIT state is ignored.
REQ-030 spi_busy=1 in a *_SEND state stalls the FSM without issuing spi_start.

Reset
REQ-031 reset=1 in any state, including mid-frame, forces LCD_RST with the following cleared: RST_CYCLES counter, init index, fb_addr and pending flag.
REQ-032 Output values during reset: lcd_rst=0, spi_start=0, spi_data=0x00, spi_dc=0, fb_rd=0, fb_addr=0, ready=0, frame_done=0.

Structure
REQ-033 The shared package lcd_pkg holds the state enum, INIT_LEN=6, the init command constants, and the CMD_SET_Y=0x40 and CMD_SET_X=0x80 constants.
REQ-034 The single sub-module lcd_init_rom maps init index to command byte combinationally.

Verification
REQ-035 Scenario 1: reset for 3 cycles, RST_CYCLES=10 -> lcd_rst=0 for exactly 10 cycles after reset releases.
REQ-036 Scenario 2: SPI model returns spi_avail 20 cycles after each start -> bytes 0x21, 0xB1, 0x04, 0x14, 0x20, 0x0C with spi_dc=0, then ready=1.
REQ-037 Scenario 3: refresh with fb_data = fb_addr[7:0] -> bytes 0x40, 0x80 (spi_dc=0), then 0x00..0xFF, 0x00..0xF7 (spi_dc=1), then one frame_done pulse.
REQ-038 Scenario 4: 3 refresh pulses during a frame -> exactly one further frame.
REQ-039 Scenario 5: reset at data byte 100 -> all outputs at their reset values next cycle, then the full init sequence replays.
REQ-040 Scenario 6: spi_busy held high for 50 cycles in CMD_SEND -> no spi_start during the hold, one spi_start after release.
